// File: rtl/dtw_pkg.sv
// Shared constants and sizing helpers for the DTW processing element.
// Path codes, operand source selects, INF value and cost width.
package dtw_pkg;

  localparam logic [1:0] PATH_DIAG = 2'b11;
  localparam logic [1:0] PATH_VERT = 2'b10;
  localparam logic [1:0] PATH_HORZ = 2'b01;
  localparam logic [1:0] PATH_NONE = 2'b00;

  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_PE   = 2'd1,
    SRC_EXT  = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  function automatic logic [63:0] dtw_inf(input int dw);
    if (dw >= 64) return '1;
    return (64'd1 << dw) - 64'd1;
  endfunction

  function automatic int cost_width(input int ndim,
                                    input int fw,
                                    input int metric);
    return $clog2(ndim) +
           ((metric != 0) ? 2 * fw + 2 : fw + 1);
  endfunction

endpackage

// File: rtl/dtw_local_cost.sv
// Combinational local cost: L1 or squared L2 over NDIM features.
// Per-feature terms are exact and summed at the full cost width.
module dtw_local_cost
  import dtw_pkg::*;
#(
  parameter int NDIM   = 3,
  parameter int FW     = 10,
  parameter int METRIC = 0,
  parameter int CW     = cost_width(NDIM, FW, METRIC)
) (
  input  logic [NDIM*FW-1:0] i_t,
  input  logic [NDIM*FW-1:0] i_r,
  output logic [CW-1:0]      o_cost
);

  localparam int TW = (METRIC != 0) ? 2 * FW + 2 : FW + 1;

  logic [TW-1:0] w_term [NDIM];
  logic [CW-1:0] w_acc;

  for (genvar k = 0; k < NDIM; k++) begin : g_ft
    logic signed [FW:0]     w_d;
    logic signed [2*FW+1:0] w_dx;
    logic [2*FW+1:0]        w_sq;
    logic [FW:0]            w_ab;

    assign w_d = $signed({i_r[k*FW+FW-1], i_r[k*FW +: FW]})
               - $signed({i_t[k*FW+FW-1], i_t[k*FW +: FW]});
    assign w_dx = {{(FW+1){w_d[FW]}}, w_d};
    assign w_sq = w_dx * w_dx;
    assign w_ab = w_d[FW] ? -w_d : w_d;
    assign w_term[k] = (METRIC != 0) ? TW'(w_sq)
                                     : TW'(w_ab);
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NDIM; k++) begin
      w_acc = w_acc + CW'(w_term[k]);
    end
  end

  assign o_cost = w_acc;

endmodule

// File: rtl/dtw_pe_pipe.sv
// Two-stage pipelined DTW cell: local cost plus min predecessor,
// saturating at INF, with traceback path and global stall.
module dtw_pe_pipe
  import dtw_pkg::*;
#(
  parameter int NDIM   = 3,
  parameter int FW     = 10,
  parameter int DW     = 16,
  parameter int METRIC = 0
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               ena,
  input  logic               i_valid,
  input  logic [DW-1:0]      D0,
  input  logic [DW-1:0]      D1,
  input  logic [DW-1:0]      D2,
  input  logic [NDIM*FW-1:0] T_pe,
  input  logic [NDIM*FW-1:0] T_ext,
  input  logic [1:0]         i_tsrc,
  input  logic [NDIM*FW-1:0] R_pe,
  input  logic [NDIM*FW-1:0] R_ext,
  input  logic [1:0]         i_rsrc,
  output logic [NDIM*FW-1:0] T,
  output logic [NDIM*FW-1:0] R,
  output logic [DW-1:0]      D,
  output logic [1:0]         o_path,
  output logic               o_valid
);

  localparam int VW = NDIM * FW;
  localparam int CW = cost_width(NDIM, FW, METRIC);
  localparam int SW = ((CW > DW) ? CW : DW) + 1;
  localparam logic [DW-1:0] INF = DW'(dtw_inf(DW));

  logic [VW-1:0] r_t, r_r, w_t, w_r;
  logic [CW-1:0] w_cost, r_cost;
  logic [DW-1:0] w_min, r_min, r_d, w_d;
  logic [1:0]    w_path, r_path, r_path2;
  logic          r_v1, r_valid, w_sat;
  logic [SW-1:0] w_sum;

  always_comb begin
    w_t = '0;
    unique case (src_e'(i_tsrc))
      SRC_HOLD: w_t = r_t;
      SRC_PE:   w_t = T_pe;
      SRC_EXT:  w_t = T_ext;
      default:  w_t = '0;
    endcase
  end

  always_comb begin
    w_r = '0;
    unique case (src_e'(i_rsrc))
      SRC_HOLD: w_r = r_r;
      SRC_PE:   w_r = R_pe;
      SRC_EXT:  w_r = R_ext;
      default:  w_r = '0;
    endcase
  end

  dtw_local_cost #(
    .NDIM  (NDIM),
    .FW    (FW),
    .METRIC(METRIC),
    .CW    (CW)
  ) u_cost (
    .i_t   (w_t),
    .i_r   (w_r),
    .o_cost(w_cost)
  );

  // Ties resolve diag > vertical > horizontal.
  always_comb begin
    w_min  = D2;
    w_path = PATH_HORZ;
    if (D0 <= D1 && D0 <= D2) begin
      w_min  = D0;
      w_path = PATH_DIAG;
    end else if (D1 <= D2) begin
      w_min  = D1;
      w_path = PATH_VERT;
    end
  end

  assign w_sum = SW'(r_cost) + SW'(r_min);
  assign w_sat = (r_min == INF) || (w_sum >= SW'(INF));
  assign w_d   = w_sat ? INF : w_sum[DW-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_t     <= '0;
      r_r     <= '0;
      r_cost  <= '0;
      r_min   <= '0;
      r_path  <= PATH_NONE;
      r_v1    <= 1'b0;
      r_d     <= '0;
      r_path2 <= PATH_NONE;
      r_valid <= 1'b0;
    end else if (ena) begin
      r_t     <= w_t;
      r_r     <= w_r;
      r_cost  <= w_cost;
      r_min   <= w_min;
      r_path  <= w_path;
      r_v1    <= i_valid;
      r_d     <= w_d;
      r_path2 <= r_path;
      r_valid <= r_v1;
    end
  end

  assign T       = r_t;
  assign R       = r_r;
  assign D       = r_d;
  assign o_path  = r_path2;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_dtw_pe_pipe.sv
// Directed bench for dtw_pe_pipe: L1 main instance plus L2
// instances (NDIM=3/DW=16 and NDIM=8/DW=32).
module tb_dtw_pe_pipe;

  logic        clk = 1'b0;
  logic        nrst, ena, iv;
  logic [15:0] d0, d1, d2;
  logic [29:0] tpe, text, rpe, rext;
  logic [1:0]  tsrc, rsrc;
  logic [29:0] to, ro, to2, ro2;
  logic [15:0] dout, dout2;
  logic [1:0]  path, path2;
  logic        ov, ov2;

  logic [79:0] tx8, rx8, z8, to8, ro8;
  logic [31:0] z32, dout8;
  logic [1:0]  path8;
  logic        ov8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtw_pe_pipe #(.NDIM(3), .FW(10), .DW(16), .METRIC(0)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .i_valid(iv),
    .D0(d0), .D1(d1), .D2(d2),
    .T_pe(tpe), .T_ext(text), .i_tsrc(tsrc),
    .R_pe(rpe), .R_ext(rext), .i_rsrc(rsrc),
    .T(to), .R(ro), .D(dout), .o_path(path), .o_valid(ov)
  );

  dtw_pe_pipe #(.NDIM(3), .FW(10), .DW(16), .METRIC(1)) u_l2 (
    .clk(clk), .nrst(nrst), .ena(ena), .i_valid(iv),
    .D0(d0), .D1(d1), .D2(d2),
    .T_pe(tpe), .T_ext(text), .i_tsrc(tsrc),
    .R_pe(rpe), .R_ext(rext), .i_rsrc(rsrc),
    .T(to2), .R(ro2), .D(dout2), .o_path(path2), .o_valid(ov2)
  );

  dtw_pe_pipe #(.NDIM(8), .FW(10), .DW(32), .METRIC(1)) u_l2n8 (
    .clk(clk), .nrst(nrst), .ena(ena), .i_valid(iv),
    .D0(z32), .D1(z32), .D2(z32),
    .T_pe(z8), .T_ext(tx8), .i_tsrc(tsrc),
    .R_pe(z8), .R_ext(rx8), .i_rsrc(rsrc),
    .T(to8), .R(ro8), .D(dout8), .o_path(path8), .o_valid(ov8)
  );

  function automatic logic [29:0] v3(input int a,
                                     input int b,
                                     input int c);
    logic [9:0] x, y, z;
    x = a[9:0];
    y = b[9:0];
    z = c[9:0];
    return {z, y, x};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step2();
    step();
    step();
  endtask

  initial begin
    nrst = 1'b0; ena = 1'b1; iv = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    tpe = '0; text = '0; rpe = '0; rext = '0;
    tsrc = 2'd0; rsrc = 2'd0;
    z8 = '0; z32 = '0;
    for (int k = 0; k < 8; k++) begin
      tx8[k*10 +: 10] = 10'h200;
      rx8[k*10 +: 10] = 10'h1FF;
    end
    #2;
    chk("rst_T", 64'(to), 64'd0);
    chk("rst_R", 64'(ro), 64'd0);
    chk("rst_D", 64'(dout), 64'd0);
    chk("rst_path", 64'(path), 64'd0);
    chk("rst_valid", 64'(ov), 64'd0);
    #10 nrst = 1'b1;

    // basic L1 cell
    rext = v3(5, -3, 100);
    text = v3(-5, 4, 90);
    d0 = 16'd7; d1 = 16'd9; d2 = 16'd8;
    iv = 1'b1; tsrc = 2'd2; rsrc = 2'd2;
    step();
    chk("load_T", 64'(to), 64'(v3(-5, 4, 90)));
    chk("load_R", 64'(ro), 64'(v3(5, -3, 100)));
    chk("lat1_valid", 64'(ov), 64'd0);
    step();
    chk("basic_D", 64'(dout), 64'd34);
    chk("basic_path", 64'(path), 64'b11);
    chk("basic_valid", 64'(ov), 64'd1);
    chk("l2_basic_D", 64'(dout2), 64'd256);

    // ties, operands held
    tsrc = 2'd0; rsrc = 2'd0;
    d0 = 16'd4; d1 = 16'd4; d2 = 16'd4;
    step2();
    chk("tie3_path", 64'(path), 64'b11);
    chk("tie3_D", 64'(dout), 64'd31);
    chk("hold_T", 64'(to), 64'(v3(-5, 4, 90)));
    d0 = 16'd6;
    step2();
    chk("tie12_path", 64'(path), 64'b10);
    chk("tie12_D", 64'(dout), 64'd31);
    d1 = 16'd6;
    step2();
    chk("horz_path", 64'(path), 64'b01);
    chk("horz_D", 64'(dout), 64'd31);

    // saturation
    d0 = 16'hFFFF; d1 = 16'hFFFF; d2 = 16'hFFFF;
    step2();
    chk("inf_D", 64'(dout), 64'hFFFF);
    chk("inf_path", 64'(path), 64'b11);
    d1 = 16'hFFF0;
    step2();
    chk("sat_D", 64'(dout), 64'hFFFF);
    chk("sat_path", 64'(path), 64'b10);
    d0 = 16'hFFE3;
    step2();
    chk("edge_nosat_D", 64'(dout), 64'hFFFE);
    d0 = 16'hFFE4;
    step2();
    chk("edge_sat_D", 64'(dout), 64'hFFFF);

    // invalid cell still updates D
    iv = 1'b0;
    d0 = 16'd1;
    step2();
    chk("inv_valid", 64'(ov), 64'd0);
    chk("inv_D", 64'(dout), 64'd28);

    // stall
    iv = 1'b1;
    d0 = 16'hFFE3;
    step2();
    chk("pre_stall_D", 64'(dout), 64'hFFFE);
    d0 = 16'd1;
    step();
    chk("stall_s1_D", 64'(dout), 64'hFFFE);
    ena = 1'b0;
    iv = 1'b0; tsrc = 2'd3; d0 = 16'd100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_D", 64'(dout), 64'hFFFE);
      chk("stall_valid", 64'(ov), 64'd1);
      chk("stall_T", 64'(to), 64'(v3(-5, 4, 90)));
    end
    ena = 1'b1;
    step();
    chk("unstall_D", 64'(dout), 64'd28);
    chk("unstall_valid", 64'(ov), 64'd1);
    chk("zero_T", 64'(to), 64'd0);

    // both sources zero
    rsrc = 2'd3; iv = 1'b1;
    d0 = 16'd5; d1 = 16'd9; d2 = 16'd9;
    step2();
    chk("zero_R", 64'(ro), 64'd0);
    chk("zero_D", 64'(dout), 64'd5);

    // extreme features
    tsrc = 2'd2; rsrc = 2'd2;
    text = v3(-512, 511, 0);
    rext = v3(511, -512, 0);
    d0 = '0; d1 = '0; d2 = '0;
    step2();
    chk("l1_ext_D", 64'(dout), 64'd2046);
    chk("l2_sat_D", 64'(dout2), 64'hFFFF);
    chk("l2n8_D", 64'(dout8), 64'd8372232);
    chk("l2n8_valid", 64'(ov8), 64'd1);

    // reset mid-stream
    d0 = 16'd3;
    step();
    nrst = 1'b0;
    #1;
    chk("mrst_D", 64'(dout), 64'd0);
    chk("mrst_path", 64'(path), 64'd0);
    chk("mrst_valid", 64'(ov), 64'd0);
    chk("mrst_T", 64'(to), 64'd0);
    chk("mrst_R", 64'(ro), 64'd0);
    iv = 1'b0;
    #2 nrst = 1'b1;
    step();
    chk("mrst_c1_valid", 64'(ov), 64'd0);
    iv = 1'b1;
    step();
    chk("mrst_c2_valid", 64'(ov), 64'd0);
    step();
    chk("mrst_c3_valid", 64'(ov), 64'd1);
    chk("mrst_c3_D", 64'(dout), 64'd2046);
    chk("mrst_c3_path", 64'(path), 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
